qsfp_port_ctrl: RTL

Parametrised management controller for N QSFP28 cages on the board top level. Per cage it sequences module reset, low-power mode and interrupt status, and it arbitrates the per-cage ModSelL lines that share one I2C bus. It sits beside the Ethernet subsystem, in the `clock` domain that the Ethernet subsystem uses. It supersedes the fixed single-cage tie-offs of qsfp0_* pins with a software-visible, multi-port control path.

---
 rtl/qsfp_ctrl_pkg.sv | 16 +
 rtl/qsfp_port_fsm.sv | 151 +++++++++++++++
 rtl/qsfp_port_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/qsfp_ctrl_pkg.sv
// Shared state encodings and counter-width helpers for the QSFP cage management controller.
package qsfp_ctrl_pkg;

  typedef enum logic [1:0] {OFF, RESET, INIT, READY} port_state_t;
  typedef enum logic [1:0] {IDLE, SETUP, GRANT, ERR} sel_state_t;

  // Wide enough to hold max_count itself so that saturating counters never wrap.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic int sel_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/qsfp_port_fsm.sv
// Per-cage pin synchroniser, presence debounce, reset/init sequencer and interrupt status.
// QSFP_INT_LATCH_EN selects latched (edge-set, software-cleared) interrupts instead of level pass-through.
module qsfp_port_fsm
  import qsfp_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES    = 256,
  parameter int INIT_CYCLES     = 65536,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clock,
  input  logic resetn,
  input  logic clock_ok,
  input  logic port_enable,
  input  logic lpmode_req,
  input  logic int_clear,
  input  logic modprsl,
  input  logic intl,
  output logic resetl,
  output logic lpmode,
  output logic present,
  output logic ready,
  output logic int_pending,
  output logic int_next
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int SEQ_MAX = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
  localparam int SW = cnt_width(SEQ_MAX);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SEQ_LIMIT = SW'(SEQ_MAX);
  localparam logic [SW-1:0] RST_LAST  = SW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] INIT_LAST = SW'(INIT_CYCLES - 1);

  logic [1:0]    prs_sync;
  logic [1:0]    int_sync;
  logic [DW-1:0] db_cnt;
  logic [SW-1:0] seq_cnt;
  port_state_t   state;
  port_state_t   state_nxt;
  logic          go_off;

  // Synchroniser flops reset to 1: absent, no interrupt.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      prs_sync <= 2'b11;
      int_sync <= 2'b11;
    end else begin
      prs_sync <= {prs_sync[0], modprsl};
      int_sync <= {int_sync[0], intl};
    end
  end

  // Counter restarts in the cycle the synchronised level changes.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      db_cnt  <= '0;
      present <= 1'b0;
    end else begin
      if (prs_sync[0] != prs_sync[1]) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_MAX) begin
        db_cnt <= db_cnt + DW'(1);
      end
      if (db_cnt == DB_MAX) begin
        present <= ~prs_sync[1];
      end
    end
  end

  assign go_off = !port_enable || !present || !clock_ok;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (go_off) begin
      state_nxt = OFF;
    end else begin
      case (state)
        OFF:     state_nxt = RESET;
        RESET:   if (seq_cnt == RST_LAST) state_nxt = INIT;
        INIT:    if (seq_cnt == INIT_LAST) state_nxt = READY;
        READY:   state_nxt = READY;
        default: state_nxt = OFF;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seq_cnt <= '0;
    end else if (state_nxt != state) begin
      seq_cnt <= '0;
    end else if (seq_cnt != SEQ_LIMIT) begin
      seq_cnt <= seq_cnt + SW'(1);
    end
  end

  // Pin outputs decode the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      resetl      <= 1'b0;
      lpmode      <= 1'b1;
      ready       <= 1'b0;
      int_pending <= 1'b0;
    end else begin
      resetl      <= (state_nxt == INIT) || (state_nxt == READY);
      lpmode      <= (state_nxt == READY) ? lpmode_req : 1'b1;
      ready       <= (state_nxt == READY);
      int_pending <= int_next;
    end
  end

`ifdef QSFP_INT_LATCH_EN
  logic int_prev;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      int_prev <= 1'b1;
    end else begin
      int_prev <= int_sync[1];
    end
  end

  // A new falling edge beats a simultaneous clear.
  always_comb begin
    int_next = 1'b0;
    if (state_nxt == READY) begin
      if (int_prev && !int_sync[1]) begin
        int_next = 1'b1;
      end else if (int_clear) begin
        int_next = 1'b0;
      end else begin
        int_next = int_pending;
      end
    end
  end
`else
  logic unused_int_clear;

  assign unused_int_clear = int_clear;
  assign int_next = !int_sync[1] && (state_nxt == READY);
`endif

endmodule

// File: rtl/qsfp_port_ctrl.sv
// Multi-cage QSFP28 management: per-port sequencers, shared-I2C ModSelL arbiter and refclk reset.
// Define QSFP_INT_LATCH_EN for latched interrupts; otherwise int_pending follows IntL.
module qsfp_port_ctrl
  import qsfp_ctrl_pkg::*;
#(
  parameter int NUM_PORTS           = 2,
  parameter int RESET_CYCLES        = 256,
  parameter int INIT_CYCLES         = 65536,
  parameter int DEBOUNCE_CYCLES     = 1024,
  parameter int SEL_SETUP_CYCLES    = 64,
  parameter int REFCLK_RESET_CYCLES = 128
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              clock_ok,
  input  logic [NUM_PORTS-1:0]              port_enable,
  input  logic [NUM_PORTS-1:0]              lpmode_req,
  input  logic [NUM_PORTS-1:0]              int_clear,
  input  logic                              sel_valid,
  input  logic [sel_width(NUM_PORTS)-1:0]   sel_port,
  output logic                              sel_grant,
  output logic                              sel_error,
  output logic [NUM_PORTS-1:0]              port_present,
  output logic [NUM_PORTS-1:0]              port_ready,
  output logic [NUM_PORTS-1:0]              int_pending,
  output logic                              irq,
  input  logic [NUM_PORTS-1:0]              qsfp_modprsl,
  input  logic [NUM_PORTS-1:0]              qsfp_intl,
  output logic [NUM_PORTS-1:0]              qsfp_resetl,
  output logic [NUM_PORTS-1:0]              qsfp_modsell,
  output logic [NUM_PORTS-1:0]              qsfp_lpmode,
  output logic                              qsfp_refclk_reset
);

  localparam int SEL_W = sel_width(NUM_PORTS);
  localparam int SCW   = cnt_width(SEL_SETUP_CYCLES);
  localparam int RW    = cnt_width(REFCLK_RESET_CYCLES);
  localparam logic [SCW-1:0] SETUP_MAX = SCW'(SEL_SETUP_CYCLES);
  localparam logic [RW-1:0]  REF_MAX   = RW'(REFCLK_RESET_CYCLES);
  localparam logic [RW-1:0]  REF_LAST  = RW'(REFCLK_RESET_CYCLES - 1);

  logic [NUM_PORTS-1:0]     int_next;
  logic [(1<<SEL_W)-1:0]    ready_pad;
  sel_state_t               sel_state;
  sel_state_t               sel_nxt;
  logic [SEL_W-1:0]         port_q;
  logic [SEL_W-1:0]         port_nxt;
  logic [SCW-1:0]           setup_cnt;
  logic [NUM_PORTS-1:0]     modsell_nxt;
  logic [RW-1:0]            ref_cnt;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    qsfp_port_fsm #(
      .RESET_CYCLES    (RESET_CYCLES),
      .INIT_CYCLES     (INIT_CYCLES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_port (
      .clock       (clock),
      .resetn      (resetn),
      .clock_ok    (clock_ok),
      .port_enable (port_enable[i]),
      .lpmode_req  (lpmode_req[i]),
      .int_clear   (int_clear[i]),
      .modprsl     (qsfp_modprsl[i]),
      .intl        (qsfp_intl[i]),
      .resetl      (qsfp_resetl[i]),
      .lpmode      (qsfp_lpmode[i]),
      .present     (port_present[i]),
      .ready       (port_ready[i]),
      .int_pending (int_pending[i]),
      .int_next    (int_next[i])
    );
  end

  // Zero-padded so an out-of-range select index reads as not ready and is refused.
  always_comb begin
    ready_pad = '0;
    ready_pad[NUM_PORTS-1:0] = port_ready;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sel_state <= IDLE;
      port_q    <= '0;
    end else begin
      sel_state <= sel_nxt;
      port_q    <= port_nxt;
    end
  end

  always_comb begin
    sel_nxt  = sel_state;
    port_nxt = port_q;
    case (sel_state)
      IDLE: begin
        if (sel_valid) begin
          port_nxt = sel_port;
          sel_nxt  = ready_pad[sel_port] ? SETUP : ERR;
        end
      end
      SETUP: begin
        if (!sel_valid)                  sel_nxt = IDLE;
        else if (!ready_pad[port_q])     sel_nxt = ERR;
        else if (setup_cnt == SETUP_MAX) sel_nxt = GRANT;
      end
      GRANT: begin
        if (!sel_valid)              sel_nxt = IDLE;
        else if (!ready_pad[port_q]) sel_nxt = ERR;
      end
      ERR: begin
        if (!sel_valid) sel_nxt = IDLE;
      end
      default: sel_nxt = IDLE;
    endcase
  end

  // Only one ModSelL may be low, and only while a select is in setup or granted.
  always_comb begin
    modsell_nxt = '1;
    if ((sel_nxt == SETUP) || (sel_nxt == GRANT)) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (port_nxt == SEL_W'(i)) modsell_nxt[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      setup_cnt    <= '0;
      sel_grant    <= 1'b0;
      sel_error    <= 1'b0;
      qsfp_modsell <= '1;
      irq          <= 1'b0;
    end else begin
      if (sel_state != SETUP) begin
        setup_cnt <= '0;
      end else if (setup_cnt != SETUP_MAX) begin
        setup_cnt <= setup_cnt + SCW'(1);
      end
      sel_grant    <= (sel_nxt == GRANT);
      sel_error    <= (sel_nxt == ERR);
      qsfp_modsell <= modsell_nxt;
      irq          <= |int_next;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ref_cnt           <= '0;
      qsfp_refclk_reset <= 1'b1;
    end else begin
      if (ref_cnt != REF_MAX) ref_cnt <= ref_cnt + RW'(1);
      qsfp_refclk_reset <= (ref_cnt < REF_LAST);
    end
  end

endmodule
